// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 64-bit register file.
package regfile_pkg;

    localparam int unsigned DATA_WIDTH_C = 64;
    localparam int unsigned ADDR_WIDTH_C = 5;
    localparam int unsigned NUM_REGS_C   = 32;
    localparam int unsigned ZERO_REG_C   = 31;

    typedef logic [ADDR_WIDTH_C-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH_C-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_register_slot.sv
// One architectural register: enabled flop bank, cleared asynchronously by reset.
module register_slot #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32-entry register file: one synchronous write port, two combinational read ports, X31 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward WriteData to a read port addressing the register being written.
module reg_file
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_C,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_C,
    parameter int unsigned ZERO_REG   = ZERO_REG_C
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int unsigned HI_W     = ADDR_WIDTH - 3;
    localparam int unsigned NUM_GRPS = 2 ** HI_W;

    logic [NUM_GRPS-1:0]   grp_en;
    logic [7:0]            lo_dec;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Upper bits pick a group of eight (gated by RegWrite), lower three bits pick within it.
    // An unknown WriteRegister with RegWrite low leaves every enable at 0.
    always_comb begin
        grp_en = '0;
        lo_dec = '0;
        for (int unsigned g = 0; g < NUM_GRPS; g++) begin
            if (RegWrite && (WriteRegister[ADDR_WIDTH-1:3] == HI_W'(g))) begin
                grp_en[g] = 1'b1;
            end
        end
        for (int unsigned j = 0; j < 8; j++) begin
            if (WriteRegister[2:0] == 3'(j)) begin
                lo_dec[j] = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
        if (i == ZERO_REG) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_reg
            register_slot #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_slot (
                .clk  (clk),
                .reset(reset),
                .en   (grp_en[i/8] & lo_dec[i%8]),
                .d    (WriteData),
                .q    (regs[i])
            );
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;

    // Reset suppresses forwarding so every read is 0 while it is held.
    assign fwd1 = RegWrite && !reset && (WriteRegister == ReadRegister1)
                  && (WriteRegister != ADDR_WIDTH'(ZERO_REG));
    assign fwd2 = RegWrite && !reset && (WriteRegister == ReadRegister2)
                  && (WriteRegister != ADDR_WIDTH'(ZERO_REG));

    assign ReadData1 = fwd1 ? WriteData : regs[ReadRegister1];
    assign ReadData2 = fwd2 ? WriteData : regs[ReadRegister2];
`else
    assign ReadData1 = regs[ReadRegister1];
    assign ReadData2 = regs[ReadRegister2];
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven bench for reg_file plus sequences for read-during-write and mid-cycle reset.
module tb_reg_file;
    import regfile_pkg::*;

    logic      clk;
    logic      reset;
    logic      RegWrite;
    reg_addr_t WriteRegister;
    reg_data_t WriteData;
    reg_addr_t ReadRegister1;
    reg_addr_t ReadRegister2;
    reg_data_t ReadData1;
    reg_data_t ReadData2;

    int checks   = 0;
    int failures = 0;

    reg_file #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(5),
        .ZERO_REG  (31)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [63:0] e1;
        logic [63:0] e2;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [63:0] pre_exp;

        vecs[0] = '{1'b1, 5'd5,  64'hDEAD_BEEF_0000_0005, 5'd5,  5'd5,  64'hDEAD_BEEF_0000_0005, 64'hDEAD_BEEF_0000_0005};
        vecs[1] = '{1'b0, 5'd0,  64'h0,                   5'd4,  5'd6,  64'h0,                   64'h0};
        vecs[2] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd5,  64'h0,                   64'hDEAD_BEEF_0000_0005};
        vecs[3] = '{1'b0, 5'd7,  64'h1234,                5'd7,  5'd7,  64'h0,                   64'h0};
        vecs[4] = '{1'b0, 5'd7,  64'h1234,                5'd7,  5'd7,  64'h0,                   64'h0};
        vecs[5] = '{1'b0, 5'd7,  64'h1234,                5'd7,  5'd7,  64'h0,                   64'h0};
        vecs[6] = '{1'b1, 5'd0,  64'h1,                   5'd0,  5'd5,  64'h1,                   64'hDEAD_BEEF_0000_0005};
        vecs[7] = '{1'b1, 5'd30, 64'h3030,                5'd30, 5'd0,  64'h3030,                64'h1};
        vecs[8] = '{1'b1, 5'd5,  64'h55,                  5'd5,  5'd30, 64'h55,                  64'h3030};
        vecs[9] = '{1'b0, 5'bxxxxx, '1,                   5'd5,  5'd0,  64'h55,                  64'h1};

        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        reset         = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            chk($sformatf("reset_p1_x%0d", i), ReadData1, 64'h0);
            chk($sformatf("reset_p2_x%0d", 31 - i), ReadData2, 64'h0);
        end

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RegWrite      = vecs[i].we;
            WriteRegister = vecs[i].wa;
            WriteData     = vecs[i].wd;
            ReadRegister1 = vecs[i].r1;
            ReadRegister2 = vecs[i].r2;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_p1", i), ReadData1, vecs[i].e1);
            chk($sformatf("vec%0d_p2", i), ReadData2, vecs[i].e2);
        end

        // Read-during-write on X10
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = 5'd10;
        WriteData     = 64'hA;
        ReadRegister1 = 5'd10;
        ReadRegister2 = 5'd31;
        @(posedge clk);
        #1;
        chk("rdw_first_write", ReadData1, 64'hA);
        @(negedge clk);
        WriteData = 64'hB;
        #1;
`ifdef REGFILE_BYPASS_EN
        pre_exp = 64'hB;
`else
        pre_exp = 64'hA;
`endif
        chk("rdw_before_edge", ReadData1, pre_exp);
        chk("rdw_zero_port2", ReadData2, 64'h0);
        @(posedge clk);
        #1;
        chk("rdw_after_edge", ReadData1, 64'hB);

        // Fill X0..X30, then reset between edges
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            RegWrite      = 1'b1;
            WriteRegister = 5'(i);
            WriteData     = 64'h100 + 64'(i);
        end
        @(negedge clk);
        RegWrite      = 1'b0;
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd30;
        #1;
        chk("fill_x0", ReadData1, 64'h100);
        chk("fill_x30", ReadData2, 64'h11E);
        #1;
        reset         = 1'b1;
        RegWrite      = 1'b1;
        WriteRegister = 5'd3;
        WriteData     = 64'h77;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            chk($sformatf("midrst_p1_x%0d", i), ReadData1, 64'h0);
            chk($sformatf("midrst_p2_x%0d", 31 - i), ReadData2, 64'h0);
        end
        ReadRegister1 = 5'd3;
        @(posedge clk);
        #1;
        chk("rst_blocks_write", ReadData1, 64'h0);
        @(negedge clk);
        #2;
        reset    = 1'b0;
        RegWrite = 1'b0;
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = 5'd3;
        WriteData     = 64'h33;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            chk($sformatf("post_p1_x%0d", i), ReadData1, (i == 3) ? 64'h33 : 64'h0);
            chk($sformatf("post_p2_x%0d", 31 - i), ReadData2, (31 - i == 3) ? 64'h33 : 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
